// File: rtl/mem_apb4_ws.sv
// APB4 slave SRAM with a fixed number of access-phase wait states and byte strobes.
// Out-of-range, misaligned and unprivileged-write accesses complete with PSLVERR.
module mem_apb4_ws #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LEN      = 8,
    parameter int WAIT     = 0,
    parameter int PROT_CHK = 1
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic [AW-1:0]   PADDR,
    input  logic            PWRITE,
    input  logic [DW-1:0]   PWDATA,
    input  logic [DW/8-1:0] PSTRB,
    input  logic [2:0]      PPROT,
    output logic [DW-1:0]   PRDATA,
    output logic            PREADY,
    output logic            PSLVERR,
    output logic [1:0]      o_dbg_state
);
    localparam int DS    = DW / 8;
    localparam int AL    = $clog2(DS);
    localparam int DEPTH = (2 ** LEN) / DS;
    localparam int IW    = LEN - AL;

    // Handshake: a transfer is one setup cycle (PSEL & ~PENABLE) followed by access
    // cycles (PSEL & PENABLE); it completes in the access cycle where PREADY = 1.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAITS = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_ready;
    logic          r_slverr;
    logic          r_write;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_wdata;
    logic [DS-1:0] r_strb;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_setup;
    logic          w_in_err;
    logic [IW-1:0] w_in_idx;
    logic          w_enter_done;
    logic          w_fin_err;
    logic          w_fin_wr;
    logic [IW-1:0] w_fin_idx;
    logic          w_commit;
    logic          w_unused;

    assign w_setup  = (r_state == IDLE) && PSEL && !PENABLE;
    assign w_in_idx = PADDR[LEN-1:AL];
    assign w_in_err = (PADDR[AW-1:LEN] != '0) || (PADDR[AL-1:0] != '0)
                   || ((PROT_CHK != 0) && PWRITE && !PPROT[0]);

    // With no wait states the response is produced on the setup edge itself, so the
    // live bus values are used there instead of the (not yet captured) registers.
    assign w_enter_done = (w_setup && (WAIT == 0))
                       || ((r_state == WAITS) && PSEL && (r_cnt == 4'd0));
    assign w_fin_err = (r_state == IDLE) ? w_in_err : r_err;
    assign w_fin_wr  = (r_state == IDLE) ? PWRITE   : r_write;
    assign w_fin_idx = (r_state == IDLE) ? w_in_idx : r_idx;

    assign w_commit = (r_state == DONE) && PSEL && PENABLE && r_ready && r_write && !r_err;
    assign w_unused = ^PPROT[2:1];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_rdata  <= '1;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_idx   <= w_in_idx;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_strb  <= PSTRB;
                        r_err   <= w_in_err;
                        r_cnt   <= (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
                        r_state <= (WAIT == 0) ? DONE : WAITS;
                    end
                end
                WAITS: begin
                    if (!PSEL) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            r_ready  <= w_enter_done;
            r_slverr <= w_enter_done && w_fin_err;
            if (w_enter_done && !w_fin_wr) begin
                r_rdata <= w_fin_err ? '0 : r_mem[w_fin_idx];
            end
        end
    end

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge PCLK) begin
        if (w_commit) begin
            for (int i = 0; i < DS; i++) begin
                if (r_strb[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign PRDATA      = r_rdata;
    assign PREADY      = r_ready;
    assign PSLVERR     = r_slverr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_apb4_ws.sv
// Bench for mem_apb4_ws: one instance with WAIT=2 and one with WAIT=0 share a bus,
// selected by tgt; expectations come from a word-array model of the memory.
module tb_mem_apb4_ws;
    logic        pclk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite, tgt;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        sel_a, sel_b;
    logic [31:0] prdata_a, prdata_b, prdata;
    logic        pready_a, pready_b, pready;
    logic        pslverr_a, pslverr_b, pslverr;
    logic [1:0]  unused_dbg_a, unused_dbg_b;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [2][64];

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [2:0]  pr;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;
    vec_t vt [13];

    assign sel_a   = psel & ~tgt;
    assign sel_b   = psel & tgt;
    assign prdata  = tgt ? prdata_b  : prdata_a;
    assign pready  = tgt ? pready_b  : pready_a;
    assign pslverr = tgt ? pslverr_b : pslverr_a;

    mem_apb4_ws #(.AW(32), .DW(32), .LEN(8), .WAIT(2), .PROT_CHK(1)) u_dut_w2 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(sel_a), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a), .o_dbg_state(unused_dbg_a)
    );

    mem_apb4_ws #(.AW(32), .DW(32), .LEN(8), .WAIT(0), .PROT_CHK(1)) u_dut_w0 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(sel_b), .PENABLE(penable),
        .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b), .o_dbg_state(unused_dbg_b)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] a, input bit wr, input logic [2:0] pr);
        return (a > 32'hFF) || (a[1:0] != 2'b00) || (wr && !pr[0]);
    endfunction

    task automatic model_write(input bit d, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st);
        for (int i = 0; i < 4; i++) begin
            if (st[i]) ref_mem[d][a[7:2]][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge pclk);
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    // One complete transfer; cyc is the access cycle (1-based) in which PREADY was seen.
    task automatic apb(input bit d, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, input bit scr,
                       output logic [31:0] rd, output logic er, output int cyc);
        @(negedge pclk);
        tgt = d; psel = 1'b1; penable = 1'b0;
        paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
        @(negedge pclk);
        penable = 1'b1;
        if (scr) begin
            paddr  = $urandom;
            pwrite = 1'($urandom_range(0, 1));
            pwdata = $urandom;
            pstrb  = 4'($urandom_range(0, 15));
            pprot  = 3'($urandom_range(0, 7));
        end
        cyc = 1;
        while (pready !== 1'b1 && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        rd = prdata;
        er = pslverr;
        if (pready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL apb_timeout: addr %h got no PREADY within %0d cycles", a, cyc);
        end
    endtask

    task automatic do_check(input bit d, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                            input logic [3:0] st, input logic [2:0] pr, input bit scr,
                            input string tag, output logic [31:0] rd);
        logic er;
        int   cyc;
        bit   e;
        e = exp_err(a, wr, pr);
        apb(d, a, wr, wd, st, pr, scr, rd, er, cyc);
        chk({tag, "_err"}, 32'(er), 32'(e));
        chk({tag, "_cyc"}, 32'(cyc), d ? 32'd1 : 32'd3);
        if (!wr) chk({tag, "_rdata"}, rd, e ? 32'd0 : ref_mem[d][a[7:2]]);
        else if (!e) model_write(d, a, wd, st);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;

        vt[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 4'hF, 3'b001, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 32'h10,        32'h0,        4'hF, 3'b001, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h10,        32'h11223344, 4'h5, 3'b001, 32'h0,        1'b0};
        vt[3]  = '{1'b0, 32'h10,        32'h0,        4'h0, 3'b001, 32'hDE22BE44, 1'b0};
        vt[4]  = '{1'b0, 32'h100,       32'h0,        4'hF, 3'b001, 32'h0,        1'b1};
        vt[5]  = '{1'b1, 32'h12,        32'hFFFFFFFF, 4'hF, 3'b001, 32'h0,        1'b1};
        vt[6]  = '{1'b0, 32'h10,        32'h0,        4'hF, 3'b001, 32'hDE22BE44, 1'b0};
        vt[7]  = '{1'b1, 32'h20,        32'h5A5A5A5A, 4'hF, 3'b000, 32'h0,        1'b1};
        vt[8]  = '{1'b0, 32'h20,        32'h0,        4'hF, 3'b001, 32'hA0A00008, 1'b0};
        vt[9]  = '{1'b0, 32'h24,        32'h0,        4'hF, 3'b000, 32'hA0A00009, 1'b0};
        vt[10] = '{1'b0, 32'h11,        32'h0,        4'hF, 3'b001, 32'h0,        1'b1};
        vt[11] = '{1'b1, 32'h1000_0010, 32'h0,        4'hF, 3'b001, 32'h0,        1'b1};
        vt[12] = '{1'b0, 32'h10,        32'h0,        4'hF, 3'b001, 32'hDE22BE44, 1'b0};

        // clock/reset
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; tgt = 1'b0;
        paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(negedge pclk);
        chk("rst_pready_a",  32'(pready_a),  32'd0);
        chk("rst_pslverr_a", 32'(pslverr_a), 32'd0);
        chk("rst_prdata_a",  prdata_a,       32'hFFFFFFFF);
        chk("rst_prdata_b",  prdata_b,       32'hFFFFFFFF);
        presetn = 1'b1;

        // known contents in both memories
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) begin
                ref_mem[d][i] = {(d == 1) ? 16'hB0B0 : 16'hA0A0, 16'(i)};
                apb(1'(d), 32'(i * 4), 1'b1, ref_mem[d][i], 4'hF, 3'b001, 1'b0, rd, er, cyc);
                chk($sformatf("fill%0d_%0d_err", d, i), 32'(er), 32'd0);
            end
        end

        // directed vectors, issued back to back on the WAIT=2 instance
        for (int i = 0; i < 13; i++) begin
            apb(1'b0, vt[i].addr, vt[i].wr, vt[i].wd, vt[i].st, vt[i].pr, 1'b0, rd, er, cyc);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_er));
            chk($sformatf("vec%0d_cyc", i), 32'(cyc), 32'd3);
            if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            else if (!vt[i].exp_er) model_write(1'b0, vt[i].addr, vt[i].wd, vt[i].st);
        end

        // abort: PSEL dropped after one access cycle
        @(negedge pclk);
        tgt = 1'b0; psel = 1'b1; penable = 1'b0;
        paddr = 32'h30; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b001;
        @(negedge pclk);
        penable = 1'b1;
        chk("abort_ready_acc1", 32'(pready), 32'd0);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        chk("abort_ready_acc2", 32'(pready), 32'd0);
        @(negedge pclk);
        chk("abort_ready_after", 32'(pready), 32'd0);
        do_check(1'b0, 32'h30, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, "abort_rd", rd);
        chk("abort_rd_old", rd, 32'hA0A0000C);

        // reset pulse during a write
        @(negedge pclk);
        tgt = 1'b0; psel = 1'b1; penable = 1'b0;
        paddr = 32'h34; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        chk("rstmid_pready",  32'(pready),  32'd0);
        chk("rstmid_pslverr", 32'(pslverr), 32'd0);
        chk("rstmid_prdata",  prdata,       32'hFFFFFFFF);
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; presetn = 1'b1;
        do_check(1'b0, 32'h34, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, "rstmid_rd", rd);
        chk("rstmid_rd_old", rd, 32'hA0A0000D);

        // zero-wait instance: write then read of the same word back to back
        do_check(1'b1, 32'h40, 1'b1, 32'h01234567, 4'hF, 3'b001, 1'b0, "w0_wr", rd);
        do_check(1'b1, 32'h40, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, "w0_rd", rd);
        chk("w0_rd_value", rd, 32'h01234567);

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            bit          d, wr, scr;
            logic [31:0] a;
            int          k;
            d   = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            scr = ($urandom_range(0, 3) == 0);
            k   = $urandom_range(0, 9);
            if (k <= 6)      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            else if (k == 7) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else if (k == 8) a = 32'($urandom_range(256, 511));
            else             a = $urandom;
            do_check(d, a, wr, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                     scr, $sformatf("rnd%0d", n), rd);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_apb4_ws.md
MEM_APB4_WS -- requirements
Module: mem_apb4_ws

Interface
REQ-001 SHALL have parameter AW, 32, PADDR width in bits.
REQ-002 SHALL have parameter DW, 32, data width; only 32 and 64 are legal.
REQ-003 SHALL have parameter LEN, 8, log2 of memory size in bytes; DEPTH = 2^LEN / (DW/8) words.
REQ-004 SHALL have parameter WAIT, 0, number of access-phase wait cycles, legal range 0..15.
REQ-005 SHALL have parameter PROT_CHK, 1; when 1, unprivileged writes are rejected.
REQ-006 SHALL have derived localparams DS = DW/8 (strobe width) and AL = log2(DS).
REQ-007 PCLK  in  1  clock; all state changes on the rising edge.
REQ-008 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-009 PSEL  in  1  slave select.
REQ-010 PENABLE  in  1  access-phase marker.
REQ-011 PADDR  in  AW  byte address.
REQ-012 PWRITE  in  1  1 = write, 0 = read.
REQ-013 PWDATA  in  DW  write data.
REQ-014 PSTRB  in  DS  byte-lane write strobes.
REQ-015 PPROT  in  3  protection; bit 0 = privileged.
REQ-016 PRDATA  out  DW  read data, registered.
REQ-017 PREADY  out  1  transfer completion, registered.
REQ-018 PSLVERR  out  1  transfer error, valid only while PREADY=1.

Function
REQ-019 FSM states: IDLE, WAITS, DONE. IDLE goes to WAITS on PSEL&~PENABLE when WAIT>0, and to DONE when WAIT=0. WAITS goes to DONE when the wait counter reaches 0. DONE returns to IDLE.
REQ-020 Wait counter is 4 bits. It is loaded with WAIT-1 on the setup edge and decrements once per WAITS cycle.
REQ-021 PREADY=1 exactly in DONE while PSEL&PENABLE; PREADY=0 otherwise. An access phase lasts WAIT+1 cycles.
REQ-022 Error is decoded at setup and held to completion. Error conditions:
  - PADDR[AW-1:LEN] != 0 (out of range)
  - PADDR[AL-1:0] != 0 (misaligned)
  - PROT_CHK=1 & PWRITE & ~PPROT[0]
REQ-023 On error: PSLVERR=1 with PREADY, memory is unchanged, and PRDATA=0 for reads.
REQ-024 Write commit occurs at the edge where PSEL&PENABLE&PREADY&PWRITE&~err. Only bytes with PSTRB[i]=1 are written; other bytes keep their old value.
REQ-025 Read: PRDATA is loaded from mem[PADDR[LEN-1:AL]] so that it is valid in the cycle PREADY=1. It holds its value otherwise.
REQ-026 PSTRB is ignored for reads.
REQ-027 Back-to-back transfers (setup directly after DONE) are supported. A read immediately after a write to the same word returns the new data.
REQ-028 PSEL deasserted before completion (abort): FSM returns to IDLE on the next edge, no write occurs, and PREADY stays 0.
REQ-029 PADDR, PWRITE, PWDATA, PSTRB and PPROT are captured at setup. Input changes during the access phase do not affect the transfer.
REQ-030 Memory contents are not cleared by reset.

Reset
REQ-031 PRESETn low SHALL asynchronously force:
  - FSM = IDLE
  - counter = 0
  - PREADY = 0
  - PSLVERR = 0
  - PRDATA = all ones
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no memory write. The first setup after release SHALL be serviced normally.

Verification (DW=32, LEN=8, WAIT=2, PROT_CHK=1)
REQ-033 Write 0x0000_0010 ← 0xDEADBEEF (PSTRB=1111, PPROT=001), then read 0x10 → PREADY high on the 3rd access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-034 Write 0x10 ← 0x11223344 with PSTRB=0101, then read 0x10 → 0xDE22BE44.
REQ-035 Read 0x0000_0100 (out of range) → PREADY with PSLVERR=1 and PRDATA=0. Write 0x12 (misaligned) → PSLVERR=1, memory unchanged.
REQ-036 Write 0x20 ← 0x5A5A5A5A with PPROT=000 → PSLVERR=1; a following read of 0x20 returns the prior contents.
REQ-037 Write 0x30 ← 0xCAFEF00D, drop PSEL after 1 access cycle, then read 0x30 → old value. Separately, pulse PRESETn low mid-write → PREADY=0, PRDATA=0xFFFFFFFF, no write.
REQ-038 Rebuild with WAIT=0 and issue back-to-back write then read of 0x40 ← 0x01234567 → each completes in 1 access cycle and the read returns 0x01234567.
